// File: rtl/saturn_fetch_buffer.sv
// Instruction-nibble prefetch unit: issues PC reads to hp48_bus, buffers the returned
// nibbles with their source address in a small FIFO, and hands them to the decoder.
module saturn_fetch_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     jump_valid,
  input  logic [19:0]              jump_addr,
  output logic                     nib_valid,
  input  logic                     nib_ready,
  output logic [3:0]               nib_data,
  output logic [19:0]              nib_addr,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fetch_error,
  output logic [19:0]              bus_address,
  output logic [3:0]               bus_command,
  input  logic [3:0]               bus_nibble_in,
  input  logic                     bus_error,
  output logic                     dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] BUSCMD_NOP     = 4'h0;
  localparam logic [3:0] BUSCMD_PC_READ = 4'h2;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [19:0]     fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [19:0]     bus_address_q, bus_address_d;
  logic [3:0]      bus_command_q, bus_command_d;
  logic            fetch_error_q, fetch_error_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      data_q [DEPTH];
  logic [3:0]      data_d [DEPTH];
  logic [19:0]     addr_q [DEPTH];
  logic [19:0]     addr_d [DEPTH];

  logic            push, pop, cap_err, issue;
  logic [CW:0]     occupancy;

  // Decoder handshake: nib_valid is high whenever the FIFO is non-empty and the head
  // (nib_data/nib_addr) is stable; the head is consumed on a rising edge where
  // nib_valid & nib_ready, except when a jump is sampled on that same edge.
  assign nib_valid   = (count_q != '0);
  assign nib_data    = nib_valid ? data_q[rd_ptr_q] : 4'h0;
  assign nib_addr    = nib_valid ? addr_q[rd_ptr_q] : 20'h0;
  assign fifo_count  = count_q;
  assign fetch_error = fetch_error_q;
  assign bus_address = bus_address_q;
  assign bus_command = bus_command_q;
  assign dbg_state   = state_q;

  always_comb begin
    pop       = nib_valid & nib_ready & ~jump_valid;
    push      = inflight_q & ~bus_error & ~jump_valid;
    cap_err   = inflight_q & bus_error & ~jump_valid;
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    // Credit counts the read still on the bus; a same-cycle pop is not credited.
    issue     = (state_q == RUN) & ~jump_valid & ~cap_err & (occupancy < (CW+1)'(DEPTH));

    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    bus_address_d = bus_address_q;
    bus_command_d = bus_command_q;
    fetch_error_d = fetch_error_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    data_d        = data_q;
    addr_d        = addr_q;

    if (jump_valid) begin
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      inflight_d    = 1'b0;
      bus_command_d = BUSCMD_NOP;
      fetch_pc_d    = jump_addr;
      fetch_error_d = 1'b0;
      state_d       = RUN;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = bus_nibble_in;
        addr_d[wr_ptr_q] = bus_address_q;
        wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (cap_err) begin
        fetch_error_d = 1'b1;
        state_d       = HALT;
      end
      if (issue) begin
        bus_address_d = fetch_pc_q;
        bus_command_d = BUSCMD_PC_READ;
        inflight_d    = 1'b1;
        fetch_pc_d    = fetch_pc_q + 20'd1;
      end else begin
        bus_command_d = BUSCMD_NOP;
        inflight_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      fetch_pc_q    <= 20'h0;
      inflight_q    <= 1'b0;
      bus_address_q <= 20'h0;
      bus_command_q <= BUSCMD_NOP;
      fetch_error_q <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= 4'h0;
        addr_q[i] <= 20'h0;
      end
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      bus_address_q <= bus_address_d;
      bus_command_q <= bus_command_d;
      fetch_error_q <= fetch_error_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      data_q        <= data_d;
      addr_q        <= addr_d;
    end
  end

endmodule

// File: tb/tb_saturn_fetch_buffer.sv
// Bench for saturn_fetch_buffer: ROM bus model, queue-based reference of the fetch
// stream, directed scenarios followed by a randomized phase.
module tb_saturn_fetch_buffer;
  localparam int DEPTH = 8;
  localparam logic [3:0] NOP = 4'h0;
  localparam logic [3:0] PCR = 4'h2;

  logic        clk = 1'b0;
  logic        reset;
  logic        jump_valid;
  logic [19:0] jump_addr;
  logic        nib_valid;
  logic        nib_ready;
  logic [3:0]  nib_data;
  logic [19:0] nib_addr;
  logic [3:0]  fifo_count;
  logic        fetch_error;
  logic [19:0] bus_address;
  logic [3:0]  bus_command;
  logic [3:0]  bus_nibble_in;
  logic        bus_error;
  logic        dbg_state;

  // bus fault injection
  bit          err_en;
  logic [19:0] err_addr;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: FIFO contents as a queue of source addresses
  logic [19:0] m_q[$];
  logic [19:0] m_pc, m_infl_addr, m_bus_addr;
  bit          m_infl, m_halt, m_err;
  logic [3:0]  m_cmd;

  logic [19:0] seen[$];

  saturn_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .jump_valid(jump_valid), .jump_addr(jump_addr),
    .nib_valid(nib_valid), .nib_ready(nib_ready), .nib_data(nib_data), .nib_addr(nib_addr),
    .fifo_count(fifo_count), .fetch_error(fetch_error), .bus_address(bus_address),
    .bus_command(bus_command), .bus_nibble_in(bus_nibble_in), .bus_error(bus_error),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rom(input logic [19:0] a);
    return a[3:0] ^ a[11:8];
  endfunction

  assign bus_nibble_in = rom(bus_address);
  assign bus_error     = err_en && (bus_command == PCR) && (bus_address == err_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = 20'h0; m_infl = 0; m_infl_addr = 20'h0; m_halt = 0; m_err = 0;
    m_cmd = NOP; m_bus_addr = 20'h0;
  endtask

  task automatic model_edge(input bit jv, input logic [19:0] ja, input bit rdy);
    int old_sz;
    bit ce;
    old_sz = m_q.size();
    if (jv) begin
      m_q.delete();
      m_pc = ja; m_infl = 0; m_halt = 0; m_err = 0; m_cmd = NOP;
    end else begin
      if (old_sz > 0 && rdy) void'(m_q.pop_front());
      ce = m_infl && err_en && (m_infl_addr == err_addr);
      if (m_infl && !ce) m_q.push_back(m_infl_addr);
      if (!m_halt && !ce && (old_sz + int'(m_infl)) < DEPTH) begin
        m_infl = 1; m_infl_addr = m_pc; m_bus_addr = m_pc; m_cmd = PCR;
        m_pc = m_pc + 20'd1;
      end else begin
        m_infl = 0; m_cmd = NOP;
      end
      if (ce) begin
        m_halt = 1; m_err = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("nib_valid", nib_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("nib_addr", nib_addr, m_q[0]);
      check("nib_data", nib_data, rom(m_q[0]));
    end
    check("fifo_count", fifo_count, m_q.size());
    check("fetch_error", fetch_error, m_err);
    check("state", dbg_state, m_halt);
    check("bus_command", bus_command, m_cmd);
    check("bus_address", bus_address, m_bus_addr);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, nib_valid, 0);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_data"}, nib_data, 0);
    check({tag, "_addr"}, nib_addr, 0);
    check({tag, "_cmd"}, bus_command, NOP);
    check({tag, "_busaddr"}, bus_address, 0);
    check({tag, "_err"}, fetch_error, 0);
  endtask

  // one clock: sample inputs, clock edge, advance model, compare
  task automatic step();
    bit jv_s, rdy_s, rst_s;
    logic [19:0] ja_s;
    jv_s = jump_valid; ja_s = jump_addr; rdy_s = nib_ready; rst_s = reset;
    if (rst_s && !jv_s && rdy_s && nib_valid) seen.push_back(nib_addr);
    @(posedge clk);
    #1;
    if (!rst_s) model_reset();
    else model_edge(jv_s, ja_s, rdy_s);
    compare_all();
  endtask

  task automatic do_jump(input logic [19:0] a, input bit rdy);
    jump_valid = 1; jump_addr = a; nib_ready = rdy;
    step();
    jump_valid = 0;
    seen.delete();
  endtask

  task automatic fill_to(input int n, input string tag);
    int k = 0;
    while (fifo_count != n && k < 30) begin
      step();
      k++;
    end
    check(tag, fifo_count, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 0; jump_valid = 0; jump_addr = 20'h0; nib_ready = 0;
    err_en = 0; err_addr = 20'h0;
    model_reset();
    #12;
    check_reset_values("rst");

    // reset release and streaming
    reset = 1; nib_ready = 1; seen.delete();
    step();
    check("rst_issue_cmd", bus_command, PCR);
    check("rst_issue_addr", bus_address, 20'h0);
    check("rst_lat_e1", nib_valid, 0);
    step();
    check("rst_lat_e2", nib_valid, 1);
    check("rst_first_addr", nib_addr, 20'h0);
    repeat (16) step();
    check("stream_count", seen.size() >= 14, 1);
    for (int i = 0; i < 14; i++)
      check("stream_order", (i < seen.size()) ? seen[i] : 20'hDEAD, i);

    // backpressure
    nib_ready = 0;
    repeat (14) step();
    check("bp_full", fifo_count, DEPTH);
    check("bp_nop", bus_command, NOP);
    begin
      logic [19:0] base;
      base = m_q[0];
      seen.delete();
      nib_ready = 1;
      repeat (10) step();
      for (int i = 0; i < DEPTH; i++)
        check("bp_drain", (i < seen.size()) ? seen[i] : 20'hDEAD, base + 20'(i));
    end

    // jump mid-stream with 5 buffered and a read in flight
    do_jump(20'h00200, 0);
    fill_to(5, "jmp_fill");
    check("jmp_inflight", bus_command, PCR);
    do_jump(20'h1F0A0, 1);
    check("jmp_gap1", nib_valid, 0);
    step();
    check("jmp_gap2", nib_valid, 0);
    step();
    check("jmp_first_valid", nib_valid, 1);
    check("jmp_first_addr", nib_addr, 20'h1F0A0);
    repeat (5) step();
    for (int i = 0; i < 5; i++)
      check("jmp_no_stale", (i < seen.size()) ? seen[i] : 20'hDEAD, 20'h1F0A0 + 20'(i));

    // back-to-back jumps, last wins
    jump_valid = 1; jump_addr = 20'h33333; step();
    do_jump(20'h44440, 1);
    repeat (4) step();
    check("b2b_first", (seen.size() > 0) ? seen[0] : 20'hDEAD, 20'h44440);

    // address wrap
    do_jump(20'hFFFFE, 1);
    repeat (8) step();
    begin
      logic [19:0] wexp [4];
      wexp = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
      for (int i = 0; i < 4; i++)
        check("wrap_seq", (i < seen.size()) ? seen[i] : 20'hDEAD, wexp[i]);
    end

    // bus error on read of 0x00004
    err_en = 1; err_addr = 20'h00004;
    do_jump(20'h00000, 1);
    repeat (12) step();
    check("err_flag", fetch_error, 1);
    check("err_nop", bus_command, NOP);
    check("err_delivered", seen.size(), 4);
    for (int i = 0; i < 4; i++)
      check("err_seq", (i < seen.size()) ? seen[i] : 20'hDEAD, i);
    err_en = 0;
    do_jump(20'h00100, 1);
    check("err_cleared", fetch_error, 0);
    repeat (6) step();
    check("err_resume", (seen.size() > 0) ? seen[0] : 20'hDEAD, 20'h00100);

    // asynchronous reset with 6 buffered and a read in flight
    do_jump(20'h00040, 0);
    fill_to(6, "ar_fill");
    check("ar_inflight", bus_command, PCR);
    #3;
    reset = 0;
    #1;
    model_reset();
    check_reset_values("ar");
    compare_all();
    repeat (2) step();
    reset = 1; nib_ready = 1; seen.delete();
    step();
    check("ar_restart_addr", bus_address, 20'h0);
    check("ar_restart_cmd", bus_command, PCR);
    repeat (5) step();
    check("ar_first", (seen.size() > 0) ? seen[0] : 20'hDEAD, 20'h0);

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      nib_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        jump_valid = 1;
        jump_addr  = ($urandom_range(0, 1) == 0) ? 20'($urandom) : 20'hFFFF8 + 20'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 0) err_en = 0;
      end else begin
        jump_valid = 0;
      end
      if (!err_en && $urandom_range(0, 39) == 0) begin
        err_en   = 1;
        err_addr = m_pc + 20'($urandom_range(0, 6));
      end
      step();
    end
    jump_valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/saturn_fetch_buffer.md
# saturn_fetch_buffer

Instruction-nibble prefetch unit between the Saturn core's decoder and `hp48_bus`. It drives `BUSCMD_PC_READ` cycles at consecutive 20-bit addresses and captures the returned nibbles into a small FIFO. It presents them to the decoder with a valid/ready handshake, together with the address each nibble came from. A jump flushes the buffer and restarts fetching at the new PC. A bus error halts fetching until the next jump.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..16.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `jump_valid`  in  1  redirect request, sampled on the rising edge of `clk`.
- `jump_addr`  in  20  new fetch address; valid when `jump_valid`=1.
- `nib_valid`  out  1  FIFO head holds a nibble.
- `nib_ready`  in  1  decoder accepts the head nibble.
- `nib_data`  out  4  head nibble.
- `nib_addr`  out  20  address the head nibble was read from.
- `fifo_count`  out  $clog2(DEPTH)+1  number of entries held.
- `fetch_error`  out  1  sticky; fetching halted after a bus error.
- `bus_address`  out  20  registered address to `hp48_bus`.
- `bus_command`  out  4  registered command: `BUSCMD_PC_READ` or `BUSCMD_NOP`, from bus_commands.v.
- `bus_nibble_in`  in  4  read data from `hp48_bus`.
- `bus_error`  in  1  bus error flag from `hp48_bus`.

## Operation
- **Reset values.** While `reset`=0:
  - state RUN, `fetch_pc`=0x00000, `inflight`=0
  - FIFO empty, `fifo_count`=0, `nib_valid`=0, `nib_data`=0, `nib_addr`=0
  - `bus_address`=0, `bus_command`=`BUSCMD_NOP`, `fetch_error`=0
- **States.**
  - RUN: normal fetching.
  - HALT: entered on an error; `bus_command`=`BUSCMD_NOP`, no issue.
- **Issue (RUN only).** Condition: no `jump_valid`, and `fifo_count`+`inflight` < DEPTH. When it holds:
  - `bus_address`<=`fetch_pc`, `bus_command`<=`BUSCMD_PC_READ`, `inflight`<=1.
  - `fetch_pc`<=`fetch_pc`+1, modulo 2^20 (0xFFFFF wraps to 0x00000).
  - Otherwise `bus_command`<=`BUSCMD_NOP` and `inflight`<=0.
  - No credit is taken for a same-cycle pop.
- **Capture.** On each edge with `inflight`=1:
  - If `bus_error`=0: push {`bus_nibble_in`, `bus_address`} into the FIFO.
  - If `bus_error`=1: discard the nibble, set `fetch_error`=1, move to HALT, drive `bus_command`<=`BUSCMD_NOP`.
- **Pop.**
  - `nib_valid`=(`fifo_count`!=0), combinational from FIFO state.
  - Pop on `nib_valid` & `nib_ready`.
  - Push and pop in the same cycle leave the count unchanged.
- **Jump.** `jump_valid` has top priority in both states:
  - Flush the FIFO (`fifo_count`<=0) and discard any in-flight nibble.
  - Load `fetch_pc`<=`jump_addr`, drive `bus_command`<=`BUSCMD_NOP`.
  - Clear `fetch_error` and enter RUN.
  - A pop in the same cycle is ignored.
  - Back-to-back jumps: the last one wins.
- **Outputs and pointers.** `bus_address` holds its last value while the command is NOP. FIFO read/write pointers wrap modulo DEPTH.

## Timing
- Read latency is 1 cycle: a command registered at edge N is answered on `bus_nibble_in` and captured at edge N+1.
- Reset release to first nibble: edge 1 issues 0x00000, edge 2 captures, and `nib_valid`=1 after edge 2.
- Jump sampled at edge J: issue at J+1, capture at J+2, `nib_valid` after J+2. The first nibble is `jump_addr`.
- Sustained throughput is 1 nibble/cycle when `nib_ready`=1 continuously.
- Full FIFO: `fifo_count`=DEPTH, or DEPTH-1 with a read in flight, stalls issue. Issue resumes on the edge after the first pop.
- Asynchronous reset mid-operation:
  - Clears all state immediately.
  - Drops `bus_command` to NOP and aborts the in-flight read; its data is never captured.

## Test plan
- **Reset and stream.** Release reset, hold `nib_ready`=1, ROM model returning address[3:0]. Required:
  - `nib_valid` rises 2 edges after release.
  - Nibbles 0,1,2,… arrive one per cycle with `nib_addr` 0x00000, 0x00001, …
- **Backpressure.** Hold `nib_ready`=0. Required:
  - `fifo_count` saturates at 8, then `bus_command` stays NOP.
  - Raise `nib_ready`: 8 buffered nibbles drain in order with no loss or duplication.
- **Jump mid-stream.** Jump to 0x1F0A0 while the FIFO holds 5 nibbles and a read is in flight. Required:
  - `nib_valid`=0 for 2 cycles.
  - Next nibble has `nib_addr`=0x1F0A0.
  - No stale nibble appears.
- **Wrap.** Jump to 0xFFFFE. Required: `nib_addr` sequence is 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- **Bus error.** Assert `bus_error` on the read of address 0x00004. Required:
  - `fetch_error`=1; only nibbles 0..3 are delivered.
  - `bus_command` is NOP thereafter.
  - A jump to 0x00100 clears `fetch_error` and resumes fetching from 0x00100.
- **Async reset mid-operation.** Pull `reset` low while the FIFO holds 6 nibbles and a read is in flight. Required:
  - Outputs take their reset values immediately, without a clock edge.
  - After release, fetching restarts at 0x00000.
